// File: rtl/sequenciador_multiciclo.sv
// Multicycle sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// turning the decoder's static flags into per-phase strobes with a memory wait-state timeout.
module sequenciador_multiciclo #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             i_escrevmem,
  input  logic             i_lermem,
  input  logic             i_jump,
  input  logic             i_halt,
  input  logic             i_escrevreg,
  input  logic             i_beqz,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ir_load,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             mem_req,
  output logic             mem_we,
  output logic             reg_we,
  output logic             busy,
  output logic             halted,
  output logic             timeout_err,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
  } state_t;

  state_t            state_q, state_d;
  logic              escrevmem_q, lermem_q, jump_q, beqz_q, escrevreg_q;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q;
  logic [CNT_W-1:0]  count_q;
  logic              expire_c;
  logic              to_fire_c;

  // Last permitted wait cycle without mem_ready; disabled when MEM_TIMEOUT is 0.
  assign expire_c = (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    ir_load   = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    reg_we    = 1'b0;
    halted    = 1'b0;
    to_fire_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (expire_c) begin
          to_fire_c = 1'b1;
          state_d   = S_HALTED;
        end
      end
      S_DECODE: begin
        state_d = i_halt ? S_HALTED : S_EXEC;
      end
      S_EXEC: begin
        if (jump_q) begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
          state_d  = S_FETCH;
        end else if (beqz_q) begin
          pc_write = 1'b1;
          pc_src   = zero ? 2'b01 : 2'b00;
          state_d  = S_FETCH;
        end else if (lermem_q || escrevmem_q) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = escrevmem_q;
        if (mem_ready) begin
          if (escrevmem_q) begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (expire_c) begin
          to_fire_c = 1'b1;
          state_d   = S_HALTED;
        end
      end
      S_WB: begin
        reg_we   = escrevreg_q;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALTED: begin
        halted = 1'b1;
        if (start) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Wait counter restarts on every completed access and on every state change.
  always_comb begin
    wait_d = '0;
    if ((state_d == state_q) && mem_req && !mem_ready) wait_d = wait_q + WAIT_W'(1);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      escrevmem_q <= 1'b0;
      lermem_q    <= 1'b0;
      jump_q      <= 1'b0;
      beqz_q      <= 1'b0;
      escrevreg_q <= 1'b0;
      wait_q      <= '0;
      timeout_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_q | to_fire_c;
      if (pc_write) count_q <= count_q + CNT_W'(1);
      if (state_q == S_DECODE) begin
        escrevmem_q <= i_escrevmem;
        lermem_q    <= i_lermem;
        jump_q      <= i_jump;
        beqz_q      <= i_beqz;
        escrevreg_q <= i_escrevreg;
      end
    end
  end

  assign busy        = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign timeout_err = timeout_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_sequenciador_multiciclo.sv
// Bench for sequenciador_multiciclo: per-cycle expected strobes are queued as each
// instruction's stimulus is planned, then popped and compared as the DUT runs it.
module tb_sequenciador_multiciclo;

  localparam int unsigned TO    = 4;
  localparam int unsigned CW    = 2;

  logic          clock = 1'b0;
  logic          resetn;
  logic          start, i_escrevmem, i_lermem, i_jump, i_halt, i_escrevreg, i_beqz;
  logic          zero, mem_ready;
  logic          ir_load, pc_write, mem_req, mem_we, reg_we, busy, halted, timeout_err;
  logic [1:0]    pc_src;
  logic [CW-1:0] instr_count;

  sequenciador_multiciclo #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock(clock), .resetn(resetn), .start(start),
    .i_escrevmem(i_escrevmem), .i_lermem(i_lermem), .i_jump(i_jump),
    .i_halt(i_halt), .i_escrevreg(i_escrevreg), .i_beqz(i_beqz),
    .zero(zero), .mem_ready(mem_ready),
    .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src),
    .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we),
    .busy(busy), .halted(halted), .timeout_err(timeout_err),
    .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  // {ir_load, pc_write, pc_src[1:0], mem_req, mem_we, reg_we, busy, halted, timeout_err}
  logic [9:0] obs;
  assign obs = {ir_load, pc_write, pc_src, mem_req, mem_we, reg_we, busy, halted, timeout_err};

  typedef struct packed {
    logic          st;
    logic          mr;
    logic          dec;
    logic          exz;
    logic [9:0]    exp;
    logic [CW-1:0] cnt;
  } ent_t;

  ent_t          sb_q[$];
  int            n_chk  = 0;
  int            n_fail = 0;
  int            cyc    = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic          exp_to  = 1'b0;
  logic [5:0]    cur_flags = '0;
  logic          cur_z     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] o(input logic il, input logic pw, input logic [1:0] ps,
                                   input logic mq, input logic mw, input logic rw,
                                   input logic b, input logic h);
    return {il, pw, ps, mq, mw, rw, b, h, exp_to};
  endfunction

  task automatic push_e(input logic st, input logic mr, input logic dec, input logic exz,
                        input logic [9:0] exp);
    ent_t e;
    e.st = st; e.mr = mr; e.dec = dec; e.exz = exz; e.exp = exp; e.cnt = exp_cnt;
    sb_q.push_back(e);
  endtask

  // Decoder flags and zero are valid only in their sampling cycle; elsewhere they carry garbage.
  task automatic drain();
    ent_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      @(posedge clock);
      #1;
      cyc++;
      start     = e.st;
      mem_ready = e.mr;
      {i_escrevmem, i_lermem, i_jump, i_halt, i_escrevreg, i_beqz} = e.dec ? cur_flags : ~cur_flags;
      zero      = e.exz ? cur_z : ~cur_z;
      #3;
      chk($sformatf("outs@%0d", cyc), 32'(obs), 32'(e.exp));
      chk($sformatf("count@%0d", cyc), 32'(instr_count), 32'(e.cnt));
    end
  endtask

  // pre: 0 = already in FETCH, 1 = start from IDLE, 2 = start from HALTED
  task automatic run_instr(input int pre, input logic [5:0] flags, input logic z,
                           input int fwait, input int mwait);
    logic sm, ld, jp, hl, wr, bq;
    {sm, ld, jp, hl, wr, bq} = flags;
    cur_flags = flags;
    cur_z     = z;
    if (pre == 1) push_e(1'b1, 1'b0, 1'b0, 1'b0, o(0, 0, 2'b00, 0, 0, 0, 0, 0));
    if (pre == 2) push_e(1'b1, 1'b0, 1'b0, 1'b0, o(0, 0, 2'b00, 0, 0, 0, 0, 1));
    for (int i = 0; i < fwait && i < int'(TO); i++)
      push_e(1'b0, 1'b0, 1'b0, 1'b0, o(0, 0, 2'b00, 1, 0, 0, 1, 0));
    if (fwait >= int'(TO)) begin
      exp_to = 1'b1;
      push_e(1'b0, 1'b0, 1'b0, 1'b0, o(0, 0, 2'b00, 0, 0, 0, 0, 1));
      drain();
      return;
    end
    push_e(1'b0, 1'b1, 1'b0, 1'b0, o(1, 0, 2'b00, 1, 0, 0, 1, 0));
    push_e(1'b0, 1'b0, 1'b1, 1'b0, o(0, 0, 2'b00, 0, 0, 0, 1, 0));
    if (hl) begin
      push_e(1'b0, 1'b0, 1'b0, 1'b0, o(0, 0, 2'b00, 0, 0, 0, 0, 1));
      drain();
      return;
    end
    if (jp) begin
      push_e(1'b0, 1'b0, 1'b0, 1'b1, o(0, 1, 2'b10, 0, 0, 0, 1, 0));
      exp_cnt++;
    end else if (bq) begin
      push_e(1'b0, 1'b0, 1'b0, 1'b1, o(0, 1, z ? 2'b01 : 2'b00, 0, 0, 0, 1, 0));
      exp_cnt++;
    end else begin
      push_e(1'b0, 1'b0, 1'b0, 1'b0, o(0, 0, 2'b00, 0, 0, 0, 1, 0));
      if (sm || ld) begin
        for (int i = 0; i < mwait; i++)
          push_e(1'b0, 1'b0, 1'b0, 1'b0, o(0, 0, 2'b00, 1, sm, 0, 1, 0));
        push_e(1'b0, 1'b1, 1'b0, 1'b0, o(0, sm, 2'b00, 1, sm, 0, 1, 0));
        if (sm) exp_cnt++;
      end
      if (!sm) begin
        push_e(1'b0, 1'b0, 1'b0, 1'b0, o(0, 1, 2'b00, 0, 0, wr, 1, 0));
        exp_cnt++;
      end
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // flags: {escrevmem, lermem, jump, halt, escrevreg, beqz}
  initial begin
    resetn = 1'b0; start = 1'b0; mem_ready = 1'b0; zero = 1'b0;
    {i_escrevmem, i_lermem, i_jump, i_halt, i_escrevreg, i_beqz} = '0;
    #2;
    chk("rst_outs", 32'(obs), 32'(0));
    chk("rst_count", 32'(instr_count), 32'(0));
    #10 resetn = 1'b1;

    run_instr(1, 6'b000010, 1'b0, 0, 0);   // ALU op from IDLE
    run_instr(0, 6'b010010, 1'b0, 0, 3);   // load, 3 wait states in MEM
    run_instr(0, 6'b100010, 1'b0, 1, 2);   // store, escrevreg ignored
    run_instr(0, 6'b000011, 1'b1, 0, 0);   // beqz taken
    run_instr(0, 6'b000011, 1'b0, 0, 0);   // beqz not taken, 5th retire wraps to 1
    run_instr(0, 6'b001011, 1'b1, 0, 0);   // jump and beqz together: jump wins
    run_instr(0, 6'b010010, 1'b0, 3, 3);   // just under the timeout in both phases
    run_instr(0, 6'b001100, 1'b0, 0, 0);   // halt overrides jump
    run_instr(2, 6'b000010, 1'b0, 0, 0);   // resume from HALTED
    run_instr(0, 6'b000010, 1'b0, 4, 0);   // fetch timeout
    run_instr(2, 6'b010000, 1'b0, 0, 0);   // load without reg write, timeout_err sticky

    // Abort a load stalled in MEM with an asynchronous reset.
    cur_flags = 6'b010000;
    push_e(1'b0, 1'b1, 1'b0, 1'b0, o(1, 0, 2'b00, 1, 0, 0, 1, 0));
    push_e(1'b0, 1'b0, 1'b1, 1'b0, o(0, 0, 2'b00, 0, 0, 0, 1, 0));
    push_e(1'b0, 1'b0, 1'b0, 1'b0, o(0, 0, 2'b00, 0, 0, 0, 1, 0));
    push_e(1'b0, 1'b0, 1'b0, 1'b0, o(0, 0, 2'b00, 1, 0, 0, 1, 0));
    drain();
    @(posedge clock);
    #1 mem_ready = 1'b0;
    #1;
    chk("pre_abort_req", 32'(mem_req), 32'(1));
    resetn = 1'b0;
    #1;
    chk("abort_outs", 32'(obs), 32'(0));
    chk("abort_count", 32'(instr_count), 32'(0));
    #2 resetn = 1'b1;
    exp_cnt = '0;
    exp_to  = 1'b0;
    run_instr(1, 6'b000010, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
